// File: rtl/icap_stream_writer_if.sv
// icap_stream_writer_if
//   Groups the FIFO read port and the ICAPE2 write port used by
//   icap_stream_writer.
//   master : the stream writer (issues fifo_rd_en, drives the ICAPE2 pins)
//   slave  : the FIFO / ICAPE2 side (supplies fifo_dout/empty/valid)
//   fifo_dout[31:0], fifo_empty, fifo_valid : FIFO read data and status
//   fifo_rd_en                              : FIFO read request
//   icape2_data_out[31:0], icape2_csib, icape2_rdwrb : ICAPE2 I, CSIB, RDWRB
interface icap_stream_writer_if;
   logic [31:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_valid;
   logic        fifo_rd_en;
   logic [31:0] icape2_data_out;
   logic        icape2_csib;
   logic        icape2_rdwrb;

   modport master (
      input  fifo_dout, fifo_empty, fifo_valid,
      output fifo_rd_en, icape2_data_out, icape2_csib, icape2_rdwrb
   );

   modport slave (
      output fifo_dout, fifo_empty, fifo_valid,
      input  fifo_rd_en, icape2_data_out, icape2_csib, icape2_rdwrb
   );
endinterface

// File: rtl/icap_stream_writer.sv
// icap_stream_writer
//   Pops 32-bit configuration words from a standard (non-FWFT) FIFO and
//   writes them to ICAPE2, with optional per-byte bit reversal and a periodic
//   forced read gap. Tracks word count, SYNC and DESYNC, and reports status.
//   icape2_clk, icape2_aresetn : clock, asynchronous active-low reset
//   start, bs_words            : start pulse and stream length in words
//   bus (master)               : FIFO read port and ICAPE2 write port
//   busy, done, error_code     : status (00 ok, 01 timeout, 10 no SYNC,
//                                11 no DESYNC)
//   word_count, sync_seen, desync_seen : stream progress
module icap_stream_writer #(
   parameter int BS_WORDS_BITS  = 22,
   parameter int CSIB_PERIOD    = 6,
   parameter bit BIT_SWAP       = 1'b1,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     icape2_clk,
   input  logic                     icape2_aresetn,
   input  logic                     start,
   input  logic [BS_WORDS_BITS-1:0] bs_words,
   icap_stream_writer_if.master     bus,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               error_code,
   output logic [BS_WORDS_BITS-1:0] word_count,
   output logic                     sync_seen,
   output logic                     desync_seen
);

   typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;

   localparam int PH_W = (CSIB_PERIOD > 1) ? $clog2(CSIB_PERIOD) : 1;
   localparam int ST_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [31:0] SYNC_WORD  = 32'hAA99_5566;
   localparam logic [31:0] DESYNC_CMD = 32'h3000_8001;
   localparam logic [31:0] DESYNC_ARG = 32'h0000_000D;

   state_t                   state_q, state_d;
   logic [BS_WORDS_BITS-1:0] bs_words_q, bs_words_d;
   logic [BS_WORDS_BITS-1:0] issued_q, issued_d;
   logic [BS_WORDS_BITS-1:0] word_count_q, word_count_d;
   logic [PH_W-1:0]          phase_q, phase_d;
   logic [ST_W-1:0]          starve_q, starve_d;
   logic                     sync_q, sync_d;
   logic                     desync_pend_q, desync_pend_d;
   logic                     desync_q, desync_d;
   logic [1:0]               err_q, err_d;
   logic [31:0]              data_q, data_d;
   logic                     csib_q, csib_d;

   logic gap;
   logic below_len;
   logic rd_en;

   function automatic logic [31:0] swap_bits(input logic [31:0] w);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 8; i++) begin
            r[8*k+i] = w[8*k+7-i];
         end
      end
      return r;
   endfunction

   // The gap slot is the last phase of each CSIB_PERIOD window.
   assign gap       = (CSIB_PERIOD != 0) && (phase_q == PH_W'(CSIB_PERIOD - 1));
   assign below_len = issued_q < bs_words_q;
   assign rd_en     = (state_q == ST_STREAM) && !bus.fifo_empty && below_len && !gap;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // the case statement leaves one unassigned and infers a latch.
      state_d       = state_q;
      bs_words_d    = bs_words_q;
      issued_d      = issued_q;
      word_count_d  = word_count_q;
      starve_d      = starve_q;
      sync_d        = sync_q;
      desync_pend_d = desync_pend_q;
      desync_d      = desync_q;
      err_d         = err_q;
      data_d        = data_q;
      csib_d        = 1'b1;
      if (CSIB_PERIOD == 0 || phase_q == PH_W'(CSIB_PERIOD - 1)) phase_d = '0;
      else                                                        phase_d = phase_q + PH_W'(1);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               bs_words_d    = bs_words;
               issued_d      = '0;
               word_count_d  = '0;
               starve_d      = '0;
               phase_d       = '0;
               sync_d        = 1'b0;
               desync_pend_d = 1'b0;
               desync_d      = 1'b0;
               err_d         = 2'b00;
               if (bs_words == '0) begin
                  state_d = ST_DONE;
                  err_d   = 2'b10;
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end
         ST_STREAM: begin
            if (rd_en) issued_d = issued_q + BS_WORDS_BITS'(1);
            if (bus.fifo_valid) begin
               data_d        = BIT_SWAP ? swap_bits(bus.fifo_dout) : bus.fifo_dout;
               csib_d        = 1'b0;
               word_count_d  = word_count_q + BS_WORDS_BITS'(1);
               starve_d      = '0;
               // Detection looks at the raw FIFO word, before any bit swap.
               if (bus.fifo_dout == SYNC_WORD) sync_d = 1'b1;
               if (desync_pend_q && sync_q && bus.fifo_dout == DESYNC_ARG) desync_d = 1'b1;
               desync_pend_d = (bus.fifo_dout == DESYNC_CMD);
            end else if (below_len) begin
               if (starve_q == ST_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d = ST_DONE;
                  err_d   = 2'b01;
               end else begin
                  starve_d = starve_q + ST_W'(1);
               end
            end
            // The last word is already on the ICAP pins this cycle.
            if (word_count_q == bs_words_q) begin
               state_d = ST_DONE;
               if (!sync_q)        err_d = 2'b10;
               else if (!desync_q) err_d = 2'b11;
               else                err_d = 2'b00;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge icape2_clk or negedge icape2_aresetn) begin
      if (!icape2_aresetn) begin
         state_q       <= ST_IDLE;
         bs_words_q    <= '0;
         issued_q      <= '0;
         word_count_q  <= '0;
         phase_q       <= '0;
         starve_q      <= '0;
         sync_q        <= 1'b0;
         desync_pend_q <= 1'b0;
         desync_q      <= 1'b0;
         err_q         <= 2'b00;
         data_q        <= '0;
         csib_q        <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state_q       <= state_d;
         bs_words_q    <= bs_words_d;
         issued_q      <= issued_d;
         word_count_q  <= word_count_d;
         phase_q       <= phase_d;
         starve_q      <= starve_d;
         sync_q        <= sync_d;
         desync_pend_q <= desync_pend_d;
         desync_q      <= desync_d;
         err_q         <= err_d;
         data_q        <= data_d;
         csib_q        <= csib_d;
      end
   end

   assign bus.fifo_rd_en      = rd_en;
   assign bus.icape2_data_out = data_q;
   assign bus.icape2_csib     = csib_q;
   assign bus.icape2_rdwrb    = 1'b0;
   assign busy                = (state_q == ST_STREAM);
   assign done                = (state_q == ST_DONE);
   assign error_code          = err_q;
   assign word_count          = word_count_q;
   assign sync_seen           = sync_q;
   assign desync_seen         = desync_q;

endmodule

// File: tb/tb_icap_stream_writer.sv
// tb_icap_stream_writer
//   Two writer instances share clock and reset: instance 0 has no read gap,
//   instance 1 forces a gap every 6 cycles. Both time out after 32 starved
//   cycles. Each instance reads a behavioural FIFO filled by the test tasks.
module tb_icap_stream_writer;
   localparam int N  = 2;
   localparam int BW = 22;
   localparam logic [31:0] SYNC = 32'hAA99_5566;
   localparam logic [31:0] DCMD = 32'h3000_8001;
   localparam logic [31:0] DARG = 32'h0000_000D;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    start_r = '0;
   logic [BW-1:0]   bs_r [N];
   logic [N-1:0]    rd_en_w, csib_w, rdwrb_w, busy_w, done_w, sync_w, desync_w;
   logic [31:0]     data_w [N];
   logic [1:0]      err_w [N];
   logic [BW-1:0]   wc_w [N];
   logic [31:0]     fmem [N][256];
   int              wp [N];
   int              rp_w [N];

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] stim [64];
   int          stim_n;
   logic [31:0] got [$];
   int first_out_k, last_out_k, done_k, rd_cnt, lat_err, rd_err, word_err;

   for (genvar g = 0; g < N; g++) begin : g_dut
      icap_stream_writer_if bus ();
      int          rp   = 0;
      logic        vld  = 1'b0;
      logic [31:0] dout = '0;

      // Standard-mode FIFO: data and valid appear one cycle after rd_en.
      assign bus.fifo_empty = (rp == wp[g]);
      assign bus.fifo_valid = vld;
      assign bus.fifo_dout  = dout;
      always @(posedge clk) begin
         if (bus.fifo_rd_en && (rp != wp[g])) begin
            dout <= fmem[g][rp % 256];
            rp   <= rp + 1;
            vld  <= 1'b1;
         end else begin
            vld  <= 1'b0;
         end
      end
      assign rp_w[g]    = rp;
      assign rd_en_w[g] = bus.fifo_rd_en;
      assign csib_w[g]  = bus.icape2_csib;
      assign rdwrb_w[g] = bus.icape2_rdwrb;
      assign data_w[g]  = bus.icape2_data_out;

      icap_stream_writer #(
         .BS_WORDS_BITS (BW),
         .CSIB_PERIOD   ((g == 0) ? 0 : 6),
         .BIT_SWAP      (1'b1),
         .TIMEOUT_CYCLES(32)
      ) dut (
         .icape2_clk    (clk),
         .icape2_aresetn(rst_n),
         .start         (start_r[g]),
         .bs_words      (bs_r[g]),
         .bus           (bus),
         .busy          (busy_w[g]),
         .done          (done_w[g]),
         .error_code    (err_w[g]),
         .word_count    (wc_w[g]),
         .sync_seen     (sync_w[g]),
         .desync_seen   (desync_w[g])
      );
   end

   // ---------------- reference model helpers ----------------
   function automatic logic [31:0] ref_swap(input logic [31:0] w);
      logic [31:0] r;
      logic [7:0]  b, o;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         b = w[8*k +: 8];
         o = '0;
         for (int i = 0; i < 8; i++) begin
            o = {o[6:0], b[0]};
            b = b >> 1;
         end
         r[8*k +: 8] = o;
      end
      return r;
   endfunction

   function automatic logic [31:0] rnd();
      logic [31:0] w;
      w = $urandom;
      if (w == SYNC || w == DCMD || w == DARG) w = w ^ 32'h100;
      return w;
   endfunction

   // Flags expected after the first n words of stim have streamed.
   task automatic ref_scan(input int n, output bit s, output bit ds);
      s  = 1'b0;
      ds = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (stim[i] == SYNC) s = 1'b1;
         if (s && i > 0 && stim[i-1] == DCMD && stim[i] == DARG) ds = 1'b1;
      end
   endtask

   function automatic logic [1:0] ref_err(input bit s, input bit ds);
      if (!s)  return 2'b10;
      if (!ds) return 2'b11;
      return 2'b00;
   endfunction

   task automatic load_std();
      stim[0] = 32'hFFFF_FFFF; stim[1] = SYNC;        stim[2] = 32'h2000_0000;
      stim[3] = DCMD;          stim[4] = DARG;        stim[5] = 32'h2000_0000;
      stim[6] = 32'h2000_0000; stim[7] = 32'h2000_0000;
      stim_n = 8;
   endtask

   // Discard what is left in FIFO d, then fill it with stim.
   task automatic fill_fifo(input int d);
      wp[d] = rp_w[d];
      for (int i = 0; i < stim_n; i++) begin
         fmem[d][wp[d] % 256] = stim[i];
         wp[d]++;
      end
   endtask

   // Starts a stream on instance d and monitors it until done (bounded).
   // Cycle k=0 is the first cycle in STREAM. rd_en is checked against the
   // issue rule, csib against rd_en two cycles earlier.
   task automatic run(input int d, input int bs, input int period, input bit mid_start);
      bit   rd_hist [512];
      logic exp_rd, exp_csib;
      int   nexp;
      got.delete();
      first_out_k = -1; last_out_k = -1; done_k = -1;
      rd_cnt = 0; lat_err = 0; rd_err = 0;
      @(negedge clk);
      bs_r[d] = BW'(bs); start_r[d] = 1'b1;
      @(negedge clk);
      start_r[d] = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (mid_start && k == 3) begin bs_r[d] = BW'(2); start_r[d] = 1'b1; end
         else start_r[d] = 1'b0;
         rd_hist[k] = rd_en_w[d];
         exp_rd = (rd_cnt < bs) && (wp[d] != rp_w[d]) &&
                  ((period == 0) || (k % period != period - 1));
         if (rd_en_w[d] !== exp_rd) rd_err++;
         exp_csib = (k < 2) ? 1'b1 : !rd_hist[k-2];
         if (csib_w[d] !== exp_csib) lat_err++;
         if (rd_en_w[d] === 1'b1) rd_cnt++;
         if (csib_w[d] === 1'b0) begin
            got.push_back(data_w[d]);
            if (first_out_k < 0) first_out_k = k;
            last_out_k = k;
         end
         if (done_w[d] === 1'b1) begin done_k = k; break; end
         @(negedge clk);
      end
      start_r[d] = 1'b0;
      nexp = (bs < stim_n) ? bs : stim_n;
      word_err = (got.size() == nexp) ? 0 : 1;
      for (int i = 0; i < got.size() && i < nexp; i++)
         if (got[i] !== ref_swap(stim[i])) word_err++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < N; d++) begin
         n_total++; if ({rd_en_w[d], csib_w[d], rdwrb_w[d], busy_w[d], done_w[d], sync_w[d], desync_w[d]} !== 7'b0100000)
            $display("FAIL reset_flags[%0d]: got %b want 0100000", d, {rd_en_w[d], csib_w[d], rdwrb_w[d], busy_w[d], done_w[d], sync_w[d], desync_w[d]}); else n_pass++;
         n_total++; if (err_w[d] !== 2'b00) $display("FAIL reset_err[%0d]: got %b want 00", d, err_w[d]); else n_pass++;
         n_total++; if (wc_w[d] !== '0) $display("FAIL reset_wc[%0d]: got %0d want 0", d, wc_w[d]); else n_pass++;
         n_total++; if (data_w[d] !== 32'h0) $display("FAIL reset_data[%0d]: got %h want 0", d, data_w[d]); else n_pass++;
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_total++; if ({csib_w[0], busy_w[0], done_w[0]} !== 3'b100)
         $display("FAIL idle_after_reset: got %b want 100", {csib_w[0], busy_w[0], done_w[0]}); else n_pass++;
   endtask

   task automatic test_full_stream();
      load_std(); fill_fifo(0);
      run(0, 8, 0, 1'b0);
      n_total++; if (word_err !== 0) $display("FAIL full_words: got %0d errors want 0", word_err); else n_pass++;
      if (got.size() > 1) begin
         n_total++; if (got[1] !== 32'h5599AA66) $display("FAIL full_swap: got %h want 5599aa66", got[1]); else n_pass++;
      end
      n_total++; if (first_out_k !== 2 || last_out_k - first_out_k + 1 !== 8)
         $display("FAIL full_csib_run: got first %0d last %0d want 2..9", first_out_k, last_out_k); else n_pass++;
      n_total++; if (rd_err !== 0 || lat_err !== 0) $display("FAIL full_timing: got rd %0d csib %0d errors want 0", rd_err, lat_err); else n_pass++;
      n_total++; if (done_k !== last_out_k + 1) $display("FAIL full_done_cycle: got %0d want %0d", done_k, last_out_k + 1); else n_pass++;
      n_total++; if (err_w[0] !== 2'b00) $display("FAIL full_err: got %b want 00", err_w[0]); else n_pass++;
      n_total++; if (wc_w[0] !== BW'(8)) $display("FAIL full_wc: got %0d want 8", wc_w[0]); else n_pass++;
      n_total++; if ({sync_w[0], desync_w[0], busy_w[0]} !== 3'b110)
         $display("FAIL full_flags: got %b want 110", {sync_w[0], desync_w[0], busy_w[0]}); else n_pass++;
   endtask

   task automatic test_zero_length();
      @(negedge clk); bs_r[0] = '0; start_r[0] = 1'b1;
      @(negedge clk); start_r[0] = 1'b0;
      n_total++; if ({done_w[0], busy_w[0], rd_en_w[0]} !== 3'b100)
         $display("FAIL zero_status: got %b want 100", {done_w[0], busy_w[0], rd_en_w[0]}); else n_pass++;
      n_total++; if (err_w[0] !== 2'b10) $display("FAIL zero_err: got %b want 10", err_w[0]); else n_pass++;
      n_total++; if (wc_w[0] !== '0) $display("FAIL zero_wc: got %0d want 0", wc_w[0]); else n_pass++;
   endtask

   task automatic test_throttle();
      load_std(); fill_fifo(1);
      run(1, 8, 6, 1'b1);
      n_total++; if (word_err !== 0) $display("FAIL thr_words: got %0d errors want 0", word_err); else n_pass++;
      n_total++; if (rd_err !== 0) $display("FAIL thr_gap: got %0d rd_en errors want 0", rd_err); else n_pass++;
      n_total++; if (lat_err !== 0) $display("FAIL thr_csib: got %0d csib errors want 0", lat_err); else n_pass++;
      n_total++; if (rd_cnt !== 8) $display("FAIL thr_reads: got %0d want 8", rd_cnt); else n_pass++;
      n_total++; if (done_k !== last_out_k + 1 || err_w[1] !== 2'b00)
         $display("FAIL thr_done: got cycle %0d err %b want cycle %0d err 00", done_k, err_w[1], last_out_k + 1); else n_pass++;
   endtask

   task automatic test_partial();
      bit s, ds;
      stim_n = 10;
      for (int i = 0; i < 10; i++) stim[i] = rnd();
      fill_fifo(0);
      run(0, 4, 0, 1'b0);
      ref_scan(4, s, ds);
      repeat (3) @(negedge clk);
      n_total++; if (rd_cnt !== 4 || rd_err !== 0) $display("FAIL part_reads: got %0d (%0d errors) want 4", rd_cnt, rd_err); else n_pass++;
      n_total++; if (wp[0] - rp_w[0] !== 6) $display("FAIL part_left: got %0d want 6", wp[0] - rp_w[0]); else n_pass++;
      n_total++; if (done_w[0] !== 1'b1 || err_w[0] !== ref_err(s, ds))
         $display("FAIL part_done: got done %b err %b want 1 %b", done_w[0], err_w[0], ref_err(s, ds)); else n_pass++;
      n_total++; if (word_err !== 0) $display("FAIL part_words: got %0d errors want 0", word_err); else n_pass++;
   endtask

   task automatic test_no_desync();
      stim[0] = rnd(); stim[1] = SYNC; stim[2] = rnd(); stim[3] = DCMD; stim[4] = rnd();
      stim_n = 5;
      fill_fifo(1);
      run(1, 5, 6, 1'b0);
      n_total++; if (err_w[1] !== 2'b11) $display("FAIL nodes_err: got %b want 11", err_w[1]); else n_pass++;
      n_total++; if ({done_w[1], sync_w[1], desync_w[1]} !== 3'b110)
         $display("FAIL nodes_flags: got %b want 110", {done_w[1], sync_w[1], desync_w[1]}); else n_pass++;
      n_total++; if (wc_w[1] !== BW'(5)) $display("FAIL nodes_wc: got %0d want 5", wc_w[1]); else n_pass++;
   endtask

   task automatic test_random();
      bit s, ds;
      int n, mode, p, q, bs;
      for (int it = 0; it < 4; it++) begin
         n = $urandom_range(6, 20);
         for (int i = 0; i < n; i++) stim[i] = rnd();
         stim_n = n;
         mode = $urandom_range(0, 3);
         p = $urandom_range(0, n - 4);
         if (mode == 1) stim[p] = SYNC;
         if (mode == 2) begin
            stim[p] = SYNC; q = $urandom_range(p + 1, n - 2);
            stim[q] = DCMD; stim[q+1] = DARG;
         end
         if (mode == 3) begin stim[p] = DCMD; stim[p+1] = DARG; stim[p+2] = SYNC; end
         bs = $urandom_range(1, n);
         fill_fifo(1);
         run(1, bs, 6, 1'b0);
         ref_scan(bs, s, ds);
         n_total++; if (err_w[1] !== ref_err(s, ds) || done_w[1] !== 1'b1)
            $display("FAIL rand%0d_err: got done %b err %b want 1 %b", it, done_w[1], err_w[1], ref_err(s, ds)); else n_pass++;
         n_total++; if ({sync_w[1], desync_w[1]} !== {s, ds})
            $display("FAIL rand%0d_flags: got %b want %b", it, {sync_w[1], desync_w[1]}, {s, ds}); else n_pass++;
         n_total++; if (wc_w[1] !== BW'(bs) || word_err !== 0)
            $display("FAIL rand%0d_words: got wc %0d (%0d errors) want %0d", it, wc_w[1], word_err, bs); else n_pass++;
         n_total++; if (rd_err !== 0 || lat_err !== 0)
            $display("FAIL rand%0d_timing: got rd %0d csib %0d errors want 0", it, rd_err, lat_err); else n_pass++;
      end
   endtask

   task automatic test_timeout();
      stim_n = 3;
      for (int i = 0; i < 3; i++) stim[i] = rnd();
      fill_fifo(0);
      run(0, 16, 0, 1'b0);
      // Last valid FIFO cycle is last_out_k-1; 32 starved cycles follow it.
      n_total++; if (done_k !== last_out_k + 32) $display("FAIL to_cycle: got %0d want %0d", done_k, last_out_k + 32); else n_pass++;
      n_total++; if (err_w[0] !== 2'b01) $display("FAIL to_err: got %b want 01", err_w[0]); else n_pass++;
      n_total++; if (wc_w[0] !== BW'(3) || word_err !== 0)
         $display("FAIL to_words: got wc %0d (%0d errors) want 3", wc_w[0], word_err); else n_pass++;
      n_total++; if (busy_w[0] !== 1'b0) $display("FAIL to_busy: got %b want 0", busy_w[0]); else n_pass++;
   endtask

   task automatic test_reset_mid_stream();
      bit hit;
      load_std(); fill_fifo(0);
      @(negedge clk); bs_r[0] = BW'(8); start_r[0] = 1'b1;
      @(negedge clk); start_r[0] = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 50 && !hit; k++) begin
         if (wc_w[0] === BW'(3)) hit = 1'b1;
         else @(negedge clk);
      end
      n_total++; if (hit !== 1'b1) $display("FAIL rstmid_reach: got wc %0d want 3", wc_w[0]); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if ({csib_w[0], rd_en_w[0], busy_w[0]} !== 3'b100)
         $display("FAIL rstmid_pins: got %b want 100", {csib_w[0], rd_en_w[0], busy_w[0]}); else n_pass++;
      n_total++; if (wc_w[0] !== '0) $display("FAIL rstmid_wc: got %0d want 0", wc_w[0]); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      load_std(); fill_fifo(0);
      run(0, 8, 0, 1'b0);
      n_total++; if (done_w[0] !== 1'b1 || err_w[0] !== 2'b00 || wc_w[0] !== BW'(8) || word_err !== 0)
         $display("FAIL rstmid_rerun: got done %b err %b wc %0d (%0d errors) want 1 00 8", done_w[0], err_w[0], wc_w[0], word_err); else n_pass++;
   endtask

   initial begin
      bs_r[0] = '0;
      bs_r[1] = '0;
      test_reset();
      test_full_stream();
      test_zero_length();
      test_throttle();
      test_partial();
      test_no_desync();
      test_random();
      test_timeout();
      test_reset_mid_stream();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
